memory_stage_lsu: RTL and testbench
===================================

Name: memory_stage_lsu

Overview:
Memory pipeline stage placed directly downstream of the execute stage. It consumes the registered M-stage signals and performs loads and stores over a single-outstanding req/ready data bus, including byte, halfword and word formatting. When the bus is slow it raises a stall to the hazard unit, and it registers results into the writeback (W) pipeline register.

Parameters:
TIMEOUT_CYCLES, 16, maximum WAIT cycles before the access is abandoned and a bus error is flagged; must be >=1.
CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  reset, asynchronous, active-high
RegWriteM  in  1  register-file write enable of the M instruction
MemWriteM  in  1  store enable
ResultSrcM  in  2  00=ALU, 01=load data, 10=PC+4; 01 marks a load
Funct3M  in  3  access size/sign (RV32I load/store funct3)
RD_M  in  5  destination register
PCPlus4M  in  32  PC+4 of the M instruction
WriteDataM  in  32  forwarded store data
ALU_ResultM  in  32  effective address / ALU result
mem_req  out  1  bus request
mem_we  out  1  1=write
mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_wstrb  out  4  byte strobes
mem_rdata  in  32  read data, valid when mem_ready=1
mem_ready  in  1  access completes this cycle
StallM  out  1  freeze F/D/E/M registers this cycle
RegWriteW  out  1  writeback enable
ResultSrcW  out  2  registered ResultSrcM
RD_W  out  5  registered RD_M
PCPlus4W  out  32  registered PCPlus4M
ALU_ResultW  out  32  registered ALU_ResultM
ReadDataW  out  32  formatted load data
MisalignW  out  1  the instruction in W was a misaligned access
BusErrW  out  1  the instruction in W timed out

Behaviour:
- Access = MemWriteM | (ResultSrcM==01). Misaligned = access & ((size H & a[0]) | (size W & a[1:0]!=0)), where a=ALU_ResultM.
- FSM states: IDLE, WAIT.
- IDLE, aligned access: mem_req=1 combinationally in the same cycle.
  - If mem_ready=1: the access completes with zero stall.
  - Else: StallM=1, latch addr/wdata/wstrb/we/funct3 internally, counter=1, go to WAIT.
- WAIT: mem_req=1, driven from the latched copies (the inputs are not used for the request).
  - StallM=1 every cycle until completion.
  - On mem_ready=1: StallM=0 that cycle, return to IDLE.
  - If counter reaches TIMEOUT_CYCLES without mem_ready: StallM=0, BusErr path, return to IDLE; counter increments once per WAIT cycle.
- Misaligned access: no bus request and no stall. W captures with RegWriteW=0 and MisalignW=1; the store is suppressed.
- Store formatting:
  - SB: wstrb = 0001<<a[1:0], wdata = {4{b}}.
  - SH: wstrb = 0011<<a[1:0], wdata = {2{h}}.
  - SW: wstrb = 1111, wdata = data.
- Load formatting: select the lane by a[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through. Undefined funct3 returns the raw word.
- W register updates every cycle StallM=0:
  - Captures the RegWrite/ResultSrc/RD/PCPlus4/ALU_Result inputs.
  - ReadDataW = formatted rdata on load completion, otherwise holds its previous value.
  - MisalignW and BusErrW are set per instruction; on timeout RegWriteW=0.
- While StallM=1: W loads a bubble (RegWriteW=0, MisalignW=0, BusErrW=0, other fields hold).
- Non-access instructions pass through with 1-cycle latency.
- Reset (any time, including mid-WAIT):
  - State IDLE, counter 0.
  - All W outputs 0.
  - mem_req, mem_we, mem_wstrb, StallM forced to 0 while reset is high. The in-flight access is dropped and no retry is made.
- At most one outstanding access. A mem_ready arriving in IDLE with no request is ignored.

Test Plan:
- SW, a=0x100, WriteData=0xDEADBEEF, mem_ready same cycle -> mem_req=1, wstrb=1111, mem_addr=0x100, StallM never 1; next cycle RegWriteW=0.
- LB, a=0x203, rdata=0x80FF_1234 with ready after 3 cycles -> StallM=1 for exactly 3 cycles with bubbles in W; then ReadDataW=0xFFFFFF80 and RegWriteW=1.
- SH, a=0x102, data=0x0000ABCD -> wstrb=1100, wdata=0xABCDABCD. LHU from the same address with rdata=0xABCD0000 -> ReadDataW=0x0000ABCD.
- LW, a=0x101 -> mem_req=0, StallM=0, next cycle MisalignW=1 and RegWriteW=0.
- Load with mem_ready stuck at 0, TIMEOUT_CYCLES=16 -> StallM high for 16 cycles, then BusErrW=1, RegWriteW=0, FSM back in IDLE.
- Reset asserted in the 2nd WAIT cycle -> mem_req, StallM and all W outputs drop to 0 immediately. After release, a new ADD (ResultSrc=00) passes through with 1-cycle latency.

Source files
------------

// File: rtl/memory_stage_lsu.sv
// ----------------------------------------------------------------------------
// memory_stage_lsu
//   Memory (M) pipeline stage. Turns the registered M-stage controls into a
//   single-outstanding req/ready bus access with byte/halfword/word
//   formatting. It holds the front of the pipe with StallM while the bus is
//   slow, abandons an access after TIMEOUT_CYCLES wait cycles, and registers
//   the results into the W pipeline register.
//
// Ports
//   clock, reset            rising-edge clock, async active-high reset
//   RegWriteM .. ALU_ResultM M-stage controls, store data, effective address
//   mem_req/we/addr/wdata/wstrb  bus request (addr word aligned, data
//                            replicated across lanes, strobes select bytes)
//   mem_rdata, mem_ready     bus response, rdata valid while ready is high
//   StallM                   freeze F/D/E/M registers this cycle
//   RegWriteW .. BusErrW     W pipeline register outputs
// ----------------------------------------------------------------------------
module memory_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  Funct3M,
    input  logic [4:0]  RD_M,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] ALU_ResultM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        StallM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW,
    output logic        MisalignW,
    output logic        BusErrW
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    // Copy of the request taken when the bus does not answer in the first
    // cycle; WAIT drives the bus only from this copy.
    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [1:0]  off;
        logic [29:0] word;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } acc_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    acc_t              lat, lat_nxt;

    logic [1:0]  off;
    logic        access, size_h, size_w, misaligned, go;
    logic [3:0]  fmt_strb;
    logic [31:0] fmt_wdata;
    logic        timeout_hit, done, cur_we, misalign_cap;
    logic [2:0]  cur_f3;
    logic [1:0]  cur_off;
    logic [31:0] load_data;

    // ------------------------------------------------------------------
    // Decode of the live M-stage instruction
    // ------------------------------------------------------------------
    assign off        = ALU_ResultM[1:0];
    assign access     = MemWriteM | (ResultSrcM == 2'b01);
    assign size_h     = (Funct3M[1:0] == 2'b01);
    assign size_w     = (Funct3M[1:0] == 2'b10);
    assign misaligned = access & ((size_h & off[0]) | (size_w & (off != 2'b00)));
    assign go         = access & ~misaligned;

    // Store lane formatting: replicate the datum across lanes, the strobes
    // pick the bytes that are actually written.
    always_comb begin
        fmt_strb  = 4'b1111;
        fmt_wdata = WriteDataM;
        case (Funct3M[1:0])
            2'b00: begin
                fmt_strb  = 4'b0001 << off;
                fmt_wdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                fmt_strb  = 4'b0011 << off;
                fmt_wdata = {2{WriteDataM[15:0]}};
            end
            default: ;
        endcase
    end

    // Load formatting: lane select by address offset, then extend.
    function automatic logic [31:0] load_fmt(input logic [31:0] d,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  o);
        logic [7:0]  b;
        logic [15:0] h;
        case (o)
            2'b00:   b = d[7:0];
            2'b01:   b = d[15:8];
            2'b10:   b = d[23:16];
            default: b = d[31:24];
        endcase
        h = o[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  load_fmt = {{24{b[7]}}, b};
            3'b001:  load_fmt = {{16{h[15]}}, h};
            3'b100:  load_fmt = {24'b0, b};
            3'b101:  load_fmt = {16'b0, h};
            default: load_fmt = d;
        endcase
    endfunction

    // Context of the access completing this cycle: live inputs in IDLE,
    // the latched copy in WAIT.
    assign cur_we    = (state == WAIT) ? lat.we     : MemWriteM;
    assign cur_f3    = (state == WAIT) ? lat.funct3 : Funct3M;
    assign cur_off   = (state == WAIT) ? lat.off    : off;
    assign load_data = load_fmt(mem_rdata, cur_f3, cur_off);

    // A late mem_ready on the last wait cycle still wins over the timeout.
    assign timeout_hit  = (state == WAIT) & ~mem_ready &
                          (cnt == CNT_W'(TIMEOUT_CYCLES));
    assign misalign_cap = (state == IDLE) & misaligned;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            lat   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            lat   <= lat_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lat_nxt   = lat;
        case (state)
            IDLE: begin
                if (go && !mem_ready) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_W'(1);
                    lat_nxt   = '{we:     MemWriteM,
                                  funct3: Funct3M,
                                  off:    off,
                                  word:   ALU_ResultM[31:2],
                                  wdata:  fmt_wdata,
                                  wstrb:  fmt_strb};
                end
            end
            WAIT: begin
                if (mem_ready || timeout_hit) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_wstrb = 4'b0000;
        mem_addr  = {ALU_ResultM[31:2], 2'b00};
        mem_wdata = fmt_wdata;
        StallM    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    mem_req   = 1'b1;
                    mem_we    = MemWriteM;
                    mem_wstrb = MemWriteM ? fmt_strb : 4'b0000;
                    StallM    = ~mem_ready;
                    done      = mem_ready;
                end
            end
            WAIT: begin
                mem_req   = 1'b1;
                mem_we    = lat.we;
                mem_wstrb = lat.we ? lat.wstrb : 4'b0000;
                mem_addr  = {lat.word, 2'b00};
                mem_wdata = lat.wdata;
                StallM    = ~(mem_ready | timeout_hit);
                done      = mem_ready;
            end
            default: ;
        endcase
        // Bus and hazard outputs go quiet for the whole reset pulse, even
        // before the state register has been cleared by it.
        if (reset) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_wstrb = 4'b0000;
            StallM    = 1'b0;
            done      = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // W pipeline register. A stalled cycle inserts a bubble; ReadDataW only
    // moves when a load actually completes.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 2'b00;
            RD_W        <= 5'd0;
            PCPlus4W    <= 32'd0;
            ALU_ResultW <= 32'd0;
            ReadDataW   <= 32'd0;
            MisalignW   <= 1'b0;
            BusErrW     <= 1'b0;
        end else if (StallM) begin
            RegWriteW <= 1'b0;
            MisalignW <= 1'b0;
            BusErrW   <= 1'b0;
        end else begin
            RegWriteW   <= RegWriteM & ~misalign_cap & ~timeout_hit;
            ResultSrcW  <= ResultSrcM;
            RD_W        <= RD_M;
            PCPlus4W    <= PCPlus4M;
            ALU_ResultW <= ALU_ResultM;
            if (done && !cur_we)
                ReadDataW <= load_data;
            MisalignW   <= misalign_cap;
            BusErrW     <= timeout_hit;
        end
    end

endmodule

// File: tb/tb_memory_stage_lsu.sv
// ----------------------------------------------------------------------------
// tb_memory_stage_lsu
//   Self-checking bench for memory_stage_lsu. Each instruction is described
//   as a transaction (controls, address, data, bus latency); the expected bus
//   activity, stall length and W contents are derived arithmetically from
//   that description and compared cycle by cycle.
// ----------------------------------------------------------------------------
module tb_memory_stage_lsu;

    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        StallM, RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;
    logic        MisalignW, BusErrW;

    int          n_vec, n_err;
    logic [31:0] exp_rd;

    memory_stage_lsu #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clock(clock), .reset(reset),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .Funct3M(Funct3M), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
        .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .RD_W(RD_W), .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW),
        .ReadDataW(ReadDataW), .MisalignW(MisalignW), .BusErrW(BusErrW)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rw, mw;
        logic [1:0]  rs;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] pc4, wd, a, rdata;
        int          lat;
    } instr_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [2:0] f3,
                                             input logic [1:0] o);
        logic [31:0] w;
        w = d >> (8 * int'(o));
        case (f3)
            3'd0: return (w & 32'hFF)   | (((w & 32'h80)   != 0) ? 32'hFFFF_FF00 : 32'h0);
            3'd1: return (w & 32'hFFFF) | (((w & 32'h8000) != 0) ? 32'hFFFF_0000 : 32'h0);
            3'd4: return w & 32'hFF;
            3'd5: return w & 32'hFFFF;
            default: return d;
        endcase
    endfunction

    function automatic int nbytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [1:0] o);
        int m;
        m = ((1 << nbytes(f3)) - 1) << int'(o);
        return 4'(m);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (nbytes(f3))
            1:       return (d & 32'hFF)   * 32'h0101_0101;
            2:       return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic bit ref_mis(input instr_t t);
        int n;
        n = nbytes(t.f3);
        if (!(t.mw || t.rs == 2'b01) || t.f3[1:0] == 2'b11) return 0;
        return (t.a % n) != 0;
    endfunction

    function automatic instr_t mk(input logic rw, input logic mw, input logic [1:0] rs,
                                  input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] rdata,
                                  input int lat);
        instr_t t;
        t.rw = rw; t.mw = mw; t.rs = rs; t.f3 = f3; t.a = a; t.wd = wd;
        t.rdata = rdata; t.lat = lat;
        t.rd = 5'($urandom); t.pc4 = $urandom;
        return t;
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        int     kind, k;
        kind = $urandom_range(0, 2);
        t = mk(1'b0, 1'b0, 2'b00, 3'($urandom), $urandom, $urandom, $urandom, 0);
        t.lat = ($urandom_range(0, 7) == 0) ? $urandom_range(15, 18) : $urandom_range(0, 4);
        case (kind)
            0: begin
                t.rw = 1'($urandom);
                t.rs = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
            end
            1: begin
                t.rw = 1'b1; t.rs = 2'b01;
                k = $urandom_range(0, 6);
                case (k)
                    0: t.f3 = 3'd0;  1: t.f3 = 3'd1;  2: t.f3 = 3'd2;
                    3: t.f3 = 3'd4;  4: t.f3 = 3'd5;  5: t.f3 = 3'd3;
                    default: t.f3 = 3'd7;
                endcase
            end
            default: begin
                t.mw = 1'b1;
                t.f3 = 3'($urandom_range(0, 2));
            end
        endcase
        if (kind != 0 && $urandom_range(0, 3) != 0) begin
            if (nbytes(t.f3) == 2) t.a[0] = 1'b0;
            if (nbytes(t.f3) == 4) t.a[1:0] = 2'b00;
        end
        return t;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input instr_t t);
        RegWriteM = t.rw; MemWriteM = t.mw; ResultSrcM = t.rs; Funct3M = t.f3;
        RD_M = t.rd; PCPlus4M = t.pc4; WriteDataM = t.wd; ALU_ResultM = t.a;
    endtask

    task automatic set_idle();
        RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0; Funct3M = 0; RD_M = 0;
        PCPlus4M = 0; WriteDataM = 0; ALU_ResultM = 0; mem_ready = 0; mem_rdata = 0;
    endtask

    // Runs one instruction to completion. With scramble set, inputs that the
    // stage must not look at while waiting are disturbed on wait cycles.
    task automatic run(input instr_t t, input bit scramble);
        bit active, mis, berr, is_st;
        int e, last;
        is_st  = t.mw;
        mis    = ref_mis(t);
        active = (t.mw || t.rs == 2'b01) && !mis;
        berr   = active && (t.lat > TO);
        e      = (t.lat > TO) ? TO : t.lat;
        last   = active ? e : 0;
        for (int c = 0; c <= last; c++) begin
            @(negedge clock);
            drive(t);
            mem_ready = active ? (c == t.lat) : 1'($urandom);
            mem_rdata = (active && c == t.lat) ? t.rdata : $urandom;
            if (scramble && c > 0) begin
                WriteDataM = $urandom;
                Funct3M    = 3'($urandom);
                MemWriteM  = 1'($urandom);
                if (c < last) ALU_ResultM = $urandom;
            end
            #1;
            chk("mem_req", mem_req, active);
            chk("StallM", StallM, active && c < e);
            chk("mem_we", mem_we, active && is_st);
            chk("mem_wstrb", mem_wstrb, (active && is_st) ? ref_strb(t.f3, t.a[1:0]) : 4'b0);
            if (active) chk("mem_addr", mem_addr, t.a & 32'hFFFF_FFFC);
            if (active && is_st) chk("mem_wdata", mem_wdata, ref_wdata(t.f3, t.wd));
            @(posedge clock);
            #1;
            if (c < last) begin
                chk("bubble_RegWriteW", RegWriteW, 0);
                chk("bubble_BusErrW", BusErrW, 0);
                chk("bubble_MisalignW", MisalignW, 0);
            end else begin
                if (active && !berr && !is_st) exp_rd = ref_load(t.rdata, t.f3, t.a[1:0]);
                chk("RegWriteW", RegWriteW, t.rw && !mis && !berr);
                chk("ResultSrcW", ResultSrcW, t.rs);
                chk("RD_W", RD_W, t.rd);
                chk("PCPlus4W", PCPlus4W, t.pc4);
                chk("ALU_ResultW", ALU_ResultW, t.a);
                chk("ReadDataW", ReadDataW, exp_rd);
                chk("MisalignW", MisalignW, mis);
                chk("BusErrW", BusErrW, berr);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        instr_t t;
        n_vec = 0; n_err = 0; exp_rd = 32'h0;
        reset = 1'b1;
        set_idle();

        // Reset state, with an aligned load presented while reset is high.
        @(negedge clock);
        ResultSrcM = 2'b01; ALU_ResultM = 32'h40;
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_StallM", StallM, 0);
        chk("rst_RegWriteW", RegWriteW, 0);
        chk("rst_ResultSrcW", ResultSrcW, 0);
        chk("rst_RD_W", RD_W, 0);
        chk("rst_PCPlus4W", PCPlus4W, 0);
        chk("rst_ALU_ResultW", ALU_ResultW, 0);
        chk("rst_ReadDataW", ReadDataW, 0);
        chk("rst_MisalignW", MisalignW, 0);
        chk("rst_BusErrW", BusErrW, 0);
        @(negedge clock);
        set_idle();
        reset = 1'b0;

        // Directed cases.
        run(mk(1'b0, 1'b1, 2'b00, 3'd2, 32'h100, 32'hDEAD_BEEF, 32'h0, 0), 1'b0);   // SW
        run(mk(1'b1, 1'b0, 2'b01, 3'd0, 32'h203, 32'h0, 32'h80FF_1234, 3), 1'b0);   // LB
        run(mk(1'b0, 1'b1, 2'b00, 3'd1, 32'h102, 32'h0000_ABCD, 32'h0, 1), 1'b0);   // SH
        run(mk(1'b1, 1'b0, 2'b01, 3'd5, 32'h102, 32'h0, 32'hABCD_0000, 2), 1'b0);   // LHU
        run(mk(1'b1, 1'b0, 2'b01, 3'd2, 32'h101, 32'h0, 32'h1111_2222, 0), 1'b0);   // LW misaligned
        run(mk(1'b1, 1'b0, 2'b01, 3'd2, 32'h400, 32'h0, 32'h5555_AAAA, 100), 1'b0); // timeout
        run(mk(1'b1, 1'b0, 2'b01, 3'd2, 32'h404, 32'h0, 32'h1234_5678, TO), 1'b0);  // ready on last wait cycle
        run(mk(1'b1, 1'b0, 2'b10, 3'd0, 32'h0, 32'h0, 32'h0, 0), 1'b0);             // JAL-style pass-through

        // Reset during the second wait cycle.
        t = mk(1'b1, 1'b0, 2'b01, 3'd2, 32'h300, 32'h0, 32'h0, 1000);
        @(negedge clock); drive(t); mem_ready = 1'b0;
        @(posedge clock);
        @(negedge clock); #1;
        chk("wait_StallM", StallM, 1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        exp_rd = 32'h0;
        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_StallM", StallM, 0);
        chk("midrst_RegWriteW", RegWriteW, 0);
        chk("midrst_RD_W", RD_W, 0);
        chk("midrst_PCPlus4W", PCPlus4W, 0);
        chk("midrst_ALU_ResultW", ALU_ResultW, 0);
        chk("midrst_ReadDataW", ReadDataW, 0);
        @(negedge clock);
        set_idle();
        reset = 1'b0;
        run(mk(1'b1, 1'b0, 2'b00, 3'd0, 32'h0000_0042, 32'h0, 32'h0, 0), 1'b0);    // ADD

        // Randomized traffic.
        for (int i = 0; i < 300; i++) run(rand_instr(), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
